vector_multiply_pipe: RTL and testbench
=======================================

Name: vector_multiply_pipe

Overview:
Parametrised, pipelined successor to the single-cycle vector multiplier. Takes a packed pair of N-lane operand vectors per beat and returns either N element-wise full-width products or their dot-product sum. It sits between the accelerator's operand fetch stream and the accumulate/writeback stream. Both sides use full valid/ready handshakes with correct backpressure and no data loss.

Parameters:
C_OP_WIDTH, 16, bits per operand lane
C_NUM_OPERANDS, 4, lanes per vector (N >= 1)
C_PIPE_DEPTH, 3, accept-to-output latency in cycles (>= 2)
C_SIGNED, 1, 1 = two's-complement operands/products, 0 = unsigned

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
datain  in  2*OP*N  [OP*N-1:0] = operand0 vector, [2*OP*N-1:OP*N] = operand1 vector, lane i at [i*OP +: OP]
datain_mode  in  1  0 = element-wise, 1 = dot product; sampled with the beat
datain_valid  in  1  input beat valid
datain_ready  out  1  block can accept a beat this cycle
dout  out  2*OP*N  lane i result at [i*2*OP +: 2*OP]
dout_mode  out  1  mode carried with the result
dout_valid  out  1  result valid
dout_ready  in  1  downstream accepts the result

Behaviour:
- Reset (rst==0 at posedge): every stage valid bit clears; dout_valid=0; dout=0; dout_mode=0. datain_ready=0 while rst==0. Data registers other than the outputs need not reset.
- Handshake: a beat is accepted when datain_valid && datain_ready. A result is consumed when dout_valid && dout_ready. dout and dout_mode stay stable while dout_valid && !dout_ready.
- Stall: stall = dout_valid && !dout_ready. When stall is high, all stages hold. datain_ready = rst && !stall, so it depends combinationally on dout_ready.
- Bubbles collapse: when not stalled, every stage advances every cycle, so an invalid stage never blocks the stages behind it.
- Latency: a beat accepted at edge k appears with dout_valid=1 after edge k+C_PIPE_DEPTH-1, i.e. C_PIPE_DEPTH-1 cycles later, when there is no stall. Throughput is 1 beat/cycle.
- Stage plan: S1 registers operands and mode. S2 registers the N products, each 2*OP bits, signed or unsigned per C_SIGNED. The remaining C_PIPE_DEPTH-2 stages are delay stages, and the final output register holds the result.
- Element-wise mode: lane i = op0[i]*op1[i], exact. A 2*OP-bit product never overflows.
- Dot mode: lane 0 = sum of all N products, computed in a 2*OP+clog2(N) accumulator and then truncated modulo 2^(2*OP). The adder tree sits in the last stage before the output register. Lanes 1..N-1 = 0.
- Mode travels with its beat, so mixed-mode back-to-back beats are legal.
- Reset mid-operation: all in-flight beats are discarded and no partial results are emitted.
- N=1: dot mode is identical to element-wise mode.

Decomposition:
- Package vector_multiply_pkg:
  - mode enum {VM_ELEMWISE=0, VM_DOT=1}
  - clog2-based sum-width function
  - lane-slice helper functions
- Sub-module vm_pipe_stage: one valid+data register stage with hold/advance, parametrised on data width.
  - It is instantiated once for each stage S1 through the output register: C_PIPE_DEPTH times in total, since S1 is accepted at edge k and the output register loads at edge k+C_PIPE_DEPTH-1.
  - The element-wise multipliers and the adder tree stay inline in the top.

Test Plan:
- Element-wise, signed, N=4, OP=16, dout_ready=1: op0={3,-2,100,-32768}, op1={5,7,-4,-32768} -> after C_PIPE_DEPTH-1 cycles dout lanes = {15,-14,-400,0x40000000}, dout_mode=0.
- Dot mode, same operands -> lane0 = 15-14-400+1073741824 = 1073741425, truncated to 32 bits; lanes 1-3 = 0.
- Backpressure: stream 10 beats with dout_ready held low for cycles 3-7 -> datain_ready=0 during the stall, dout held stable, all 10 results delivered in order with none lost or duplicated.
- Bubbles and mixed mode: alternate mode bits, datain_valid at 50% random duty -> every dout_mode matches its beat and results match the scoreboard.
- Unsigned build (C_SIGNED=0): op0=op1=0xFFFF, element-wise -> lane = 0xFFFE0001; dot N=4 -> lane0 = (4*0xFFFE0001) mod 2^32 = 0xFFF80004.
- Reset mid-stream: assert rst=0 with 2 beats in flight -> dout_valid=0 on the following edge, no stale outputs after release, and the first new beat returns with the nominal latency.

Source files
------------

// File: rtl/vector_multiply_pkg.sv
// Shared types and helpers for the pipelined vector multiplier: beat mode encoding,
// accumulator sizing and lane bit-offset calculations.
package vector_multiply_pkg;

    typedef enum logic {
        VM_ELEMWISE = 1'b0,
        VM_DOT      = 1'b1
    } vm_mode_e;

    // Width needed to sum num_lanes products of prod_width bits without overflow.
    function automatic int vm_sum_width(input int prod_width, input int num_lanes);
        return prod_width + $clog2(num_lanes);
    endfunction

    function automatic int vm_lane_lsb(input int lane, input int lane_width);
        return lane * lane_width;
    endfunction

    // Operand-1 lanes sit above the whole operand-0 vector in the packed beat.
    function automatic int vm_op1_lsb(input int lane, input int lane_width, input int num_lanes);
        return (num_lanes + lane) * lane_width;
    endfunction

endpackage

// File: rtl/vm_pipe_stage.sv
// One valid+data pipeline register; loads every cycle while advancing (bubbles included)
// and holds its contents otherwise.
module vm_pipe_stage #(
    parameter int C_WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance_i,
    input  logic               valid_i,
    input  logic [C_WIDTH-1:0] data_i,
    output logic               valid_o,
    output logic [C_WIDTH-1:0] data_o
);

    logic               valid_d;
    logic               valid_q;
    logic [C_WIDTH-1:0] data_d;
    logic [C_WIDTH-1:0] data_q;

    // Next-state select: take the upstream stage when advancing, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (advance_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/vector_multiply_pipe.sv
// Pipelined N-lane vector multiplier: element-wise full-width products or their dot
// product, with valid/ready handshakes on both sides and a global stall.
module vector_multiply_pipe
    import vector_multiply_pkg::*;
#(
    parameter int C_OP_WIDTH     = 16,
    parameter int C_NUM_OPERANDS = 4,
    parameter int C_PIPE_DEPTH   = 3,
    parameter bit C_SIGNED       = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [2*C_OP_WIDTH*C_NUM_OPERANDS-1:0] datain,
    input  logic                                   datain_mode,
    input  logic                                   datain_valid,
    output logic                                   datain_ready,
    output logic [2*C_OP_WIDTH*C_NUM_OPERANDS-1:0] dout,
    output logic                                   dout_mode,
    output logic                                   dout_valid,
    input  logic                                   dout_ready
);

    localparam int OPW = C_OP_WIDTH;
    localparam int N   = C_NUM_OPERANDS;
    localparam int D   = C_PIPE_DEPTH;
    localparam int PW  = 2 * OPW;
    localparam int RW  = PW * N;
    localparam int DW  = RW + 1;
    localparam int SW  = vm_sum_width(PW, N);

    logic                  stall_s;
    logic                  advance_s;
    logic [D-1:0][DW-1:0]  stage_in_s;
    logic [D-1:0][DW-1:0]  stage_out_s;
    logic [D-1:0]          stage_vin_s;
    logic [D-1:0]          stage_vout_s;
    logic [RW-1:0]         prod_s;
    logic [OPW-1:0]        op_a_s;
    logic [OPW-1:0]        op_b_s;
    logic [PW-1:0]         ext_a_s;
    logic [PW-1:0]         ext_b_s;
    logic [DW-1:0]         red_src_s;
    logic [DW-1:0]         red_s;
    logic [SW-1:0]         acc_s;
    logic [SW-1:0]         acc_term_s;
    logic                  acc_unused_s;

    assign stall_s      = dout_valid && !dout_ready;
    assign advance_s    = !stall_s;
    assign datain_ready = rst && !stall_s;

    // Lane multipliers on the S1 operands; sign/zero extension to 2*OP keeps the product exact.
    always_comb begin
        prod_s  = '0;
        op_a_s  = '0;
        op_b_s  = '0;
        ext_a_s = '0;
        ext_b_s = '0;
        for (int i = 0; i < N; i++) begin
            op_a_s  = stage_out_s[0][vm_lane_lsb(i, OPW) +: OPW];
            op_b_s  = stage_out_s[0][vm_op1_lsb(i, OPW, N) +: OPW];
            ext_a_s = {{OPW{C_SIGNED & op_a_s[OPW-1]}}, op_a_s};
            ext_b_s = {{OPW{C_SIGNED & op_b_s[OPW-1]}}, op_b_s};
            prod_s[vm_lane_lsb(i, PW) +: PW] = ext_a_s * ext_b_s;
        end
    end

    // With only two stages the adder tree has to follow the multipliers directly.
    if (D == 2) begin : g_red_direct
        assign red_src_s = {stage_out_s[0][RW], prod_s};
    end else begin : g_red_delayed
        assign red_src_s = stage_out_s[D-2];
    end

    // Dot-product adder tree in front of the output register; element-wise beats pass through.
    always_comb begin
        acc_s      = '0;
        acc_term_s = '0;
        red_s      = red_src_s;
        if (vm_mode_e'(red_src_s[RW]) == VM_DOT) begin
            for (int i = 0; i < N; i++) begin
                acc_term_s         = {SW{C_SIGNED & red_src_s[vm_lane_lsb(i, PW) + PW - 1]}};
                acc_term_s[PW-1:0] = red_src_s[vm_lane_lsb(i, PW) +: PW];
                acc_s              = acc_s + acc_term_s;
            end
            red_s[RW-1:0] = '0;
            red_s[PW-1:0] = acc_s[PW-1:0];
        end else begin
            red_s = red_src_s;
        end
    end

    // Carry bits above 2*OP are deliberately dropped by the modulo truncation.
    assign acc_unused_s = ^acc_s;

    // Stage input routing: S1 takes the beat, S2 the products, the output register the reduced result.
    always_comb begin
        stage_in_s     = '0;
        stage_vin_s    = '0;
        stage_in_s[0]  = {datain_mode, datain};
        stage_vin_s[0] = datain_valid && datain_ready;
        for (int j = 1; j < D; j++) begin
            stage_in_s[j]  = stage_out_s[j-1];
            stage_vin_s[j] = stage_vout_s[j-1];
        end
        stage_in_s[1]   = {stage_out_s[0][RW], prod_s};
        stage_in_s[D-1] = red_s;
    end

    for (genvar g = 0; g < D; g++) begin : g_stage
        vm_pipe_stage #(
            .C_WIDTH (DW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance_i (advance_s),
            .valid_i   (stage_vin_s[g]),
            .data_i    (stage_in_s[g]),
            .valid_o   (stage_vout_s[g]),
            .data_o    (stage_out_s[g])
        );
    end

    assign dout       = stage_out_s[D-1][RW-1:0];
    assign dout_mode  = stage_out_s[D-1][RW];
    assign dout_valid = stage_vout_s[D-1];

endmodule

// File: tb/tb_vector_multiply_pipe.sv
// Directed/random bench for vector_multiply_pipe: a signed and an unsigned build share
// one stimulus stream and are checked against a queue-based scoreboard.
module tb_vector_multiply_pipe;

    localparam int OP = 16;
    localparam int N  = 4;
    localparam int D  = 3;
    localparam int RW = 2 * OP * N;

    typedef struct packed {
        logic [RW-1:0] es;
        logic [RW-1:0] eu;
        logic          m;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [RW-1:0] datain;
    logic          datain_mode;
    logic          datain_valid;
    logic          dout_ready;
    logic          ready_s, ready_u;
    logic [RW-1:0] dout_s, dout_u;
    logic          mode_s, mode_u;
    logic          valid_s, valid_u;

    exp_t exp_q[$];
    int   due_q[$];
    int   cyc;
    int   n_pass;
    int   n_total;
    logic after_reset;

    vector_multiply_pipe #(
        .C_OP_WIDTH(OP), .C_NUM_OPERANDS(N), .C_PIPE_DEPTH(D), .C_SIGNED(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst), .datain(datain), .datain_mode(datain_mode),
        .datain_valid(datain_valid), .datain_ready(ready_s), .dout(dout_s),
        .dout_mode(mode_s), .dout_valid(valid_s), .dout_ready(dout_ready)
    );

    vector_multiply_pipe #(
        .C_OP_WIDTH(OP), .C_NUM_OPERANDS(N), .C_PIPE_DEPTH(D), .C_SIGNED(1'b0)
    ) dut_u (
        .clk(clk), .rst(rst), .datain(datain), .datain_mode(datain_mode),
        .datain_valid(datain_valid), .datain_ready(ready_u), .dout(dout_u),
        .dout_mode(mode_u), .dout_valid(valid_u), .dout_ready(dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] model(input logic [RW-1:0] d, input logic m, input bit sgn);
        logic [RW-1:0] r;
        logic [OP-1:0] a, b;
        logic [63:0]   pv;
        longint        p, sum;
        r   = '0;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            a = d[i*OP +: OP];
            b = d[(N+i)*OP +: OP];
            if (sgn) p = longint'($signed(a)) * longint'($signed(b));
            else     p = longint'(a) * longint'(b);
            pv = p;
            r[i*2*OP +: 2*OP] = pv[2*OP-1:0];
            sum = sum + p;
        end
        if (m) begin
            r  = '0;
            pv = sum;
            r[2*OP-1:0] = pv[2*OP-1:0];
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive, check outputs at negedge, update scoreboard at the edge.
    task automatic step(input logic v, input logic m, input logic [RW-1:0] d,
                        input logic rdy, input logic rst_v, output logic accepted);
        logic exp_valid, exp_ready;
        rst          = rst_v;
        datain_valid = v;
        datain_mode  = m;
        datain       = d;
        dout_ready   = rdy;
        @(negedge clk);
        exp_valid = (due_q.size() > 0) && (cyc >= due_q[0]);
        exp_ready = rst_v && !(exp_valid && !rdy);
        check("valid_s", RW'(valid_s), RW'(exp_valid));
        check("valid_u", RW'(valid_u), RW'(exp_valid));
        check("ready_s", RW'(ready_s), RW'(exp_ready));
        check("ready_u", RW'(ready_u), RW'(exp_ready));
        if (exp_valid) begin
            check("dout_s", dout_s, exp_q[0].es);
            check("dout_u", dout_u, exp_q[0].eu);
            check("mode_s", RW'(mode_s), RW'(exp_q[0].m));
            check("mode_u", RW'(mode_u), RW'(exp_q[0].m));
        end
        if (after_reset) begin
            check("rst_dout_s", dout_s, '0);
            check("rst_mode_s", RW'(mode_s), '0);
            check("rst_dout_u", dout_u, '0);
        end
        accepted = v && exp_ready;
        @(posedge clk);
        cyc = cyc + 1;
        if (!rst_v) begin
            exp_q.delete();
            due_q.delete();
            after_reset = 1'b1;
        end else begin
            after_reset = 1'b0;
            if (exp_valid && !rdy) begin
                foreach (due_q[i]) due_q[i] = due_q[i] + 1;
            end
            if (exp_valid && rdy) begin
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            if (accepted) begin
                exp_q.push_back('{es: model(d, m, 1'b1), eu: model(d, m, 1'b0), m: m});
                due_q.push_back(cyc + D - 1);
            end
        end
        #1;
    endtask

    initial begin
        logic          acc;
        logic          mt;
        logic [RW-1:0] vec;
        logic [RW-1:0] ones;
        logic [RW-1:0] cur;
        int            b;

        n_pass       = 0;
        n_total      = 0;
        cyc          = 0;
        rst          = 1'b0;
        datain       = '0;
        datain_mode  = 1'b0;
        datain_valid = 1'b0;
        dout_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        after_reset = 1'b1;
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, acc);

        // op0 = {3,-2,100,-32768}, op1 = {5,7,-4,-32768}
        vec = {16'h8000, 16'hFFFC, 16'd7, 16'd5, 16'h8000, 16'd100, 16'hFFFE, 16'd3};
        step(1'b1, 1'b0, vec, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        check("elem_lat_valid", RW'(valid_s), RW'(1'b1));
        check("elem_const_s", dout_s, {32'h40000000, 32'hFFFFFE70, 32'hFFFFFFF2, 32'h0000000F});
        check("elem_const_u", dout_u, {32'h40000000, 32'h0063FE70, 32'h0006FFF2, 32'h0000000F});

        step(1'b1, 1'b1, vec, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        check("dot_const_s", dout_s, {96'h0, 32'h3FFFFE71});
        check("dot_const_u", dout_u, {96'h0, 32'h406AFE71});
        check("dot_mode", RW'(mode_s), RW'(1'b1));

        ones = {RW{1'b1}};
        step(1'b1, 1'b0, ones, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        check("ffff_elem_u", dout_u, {4{32'hFFFE0001}});
        check("ffff_elem_s", dout_s, {4{32'h00000001}});
        step(1'b1, 1'b1, ones, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        check("ffff_dot_u", dout_u, {96'h0, 32'hFFF80004});
        check("ffff_dot_s", dout_s, {96'h0, 32'h00000004});

        // Backpressure: 10 beats, dout_ready low for cycles 3..7.
        b   = 0;
        cur = rand_vec();
        for (int c = 0; c < 40 && (b < 10 || exp_q.size() > 0); c++) begin
            step(b < 10, b[0], cur, !(c >= 3 && c <= 7), 1'b1, acc);
            if (acc) begin
                b   = b + 1;
                cur = rand_vec();
            end
        end
        check("bp_beats", RW'(b), RW'(10));
        check("bp_drained", RW'(exp_q.size()), '0);

        // Bubbles and alternating modes with random ready.
        mt  = 1'b0;
        cur = rand_vec();
        for (int c = 0; c < 60; c++) begin
            step($urandom_range(0, 1) == 1, mt, cur, $urandom_range(0, 3) != 0, 1'b1, acc);
            if (acc) begin
                mt  = ~mt;
                cur = rand_vec();
            end
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        end
        check("mix_drained", RW'(exp_q.size()), '0);

        // Reset with two beats in flight, then nominal latency afterwards.
        step(1'b1, 1'b0, rand_vec(), 1'b1, 1'b1, acc);
        step(1'b1, 1'b1, rand_vec(), 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);
        check("rst_valid_now", RW'(valid_s), '0);
        repeat (3) step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        step(1'b1, 1'b1, vec, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        check("post_rst_lat", RW'(valid_s), RW'(1'b1));
        check("post_rst_dot", dout_s, {96'h0, 32'h3FFFFE71});
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
        end
        check("final_drained", RW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
